// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
//   md_state_e  : mul/div sequencer state (RUN, MD_BUSY)
//   REG_IDX_W   : architectural register index width
//   MD_LAT_DEF  : default number of cycles a mul/div occupies EX
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int REG_IDX_W  = 5;
    localparam int MD_LAT_DEF = 8;

endpackage

// File: rtl/pipe_md_timer.sv
// Mul/div occupancy timer. Starts when a mul/div op enters EX in RUN,
// counts EX cycles while the pipeline is not frozen by a memory wait and
// raises md_done on the last occupancy cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : EX holds a mul/div op (only acted on in RUN)
//   hold      : memory wait, freezes state and count
//   md_stall  : front end must be held for the mul/div op this cycle
//   md_done   : single-cycle pulse, mul/div result valid in EX
module pipe_md_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic md_stall,
    output logic md_done
);

    localparam int MW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MW-1:0] TC_VAL = MW'(MD_LAT - 1);

    md_state_e     state;
    logic [MW-1:0] cnt;
    logic          tc;

    assign tc       = (state == MD_BUSY) && (cnt == TC_VAL);
    // A frozen terminal cycle is not a completion; the result is reported
    // on the first cycle the pipeline is allowed to move again.
    assign md_done  = tc && !hold;
    assign md_stall = ((state == RUN) && start) || ((state == MD_BUSY) && !tc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!hold) begin
            case (state)
                RUN: begin
                    if (start) begin
                        state <= MD_BUSY;
                        cnt   <= MW'(1);
                    end
                end
                MD_BUSY: begin
                    if (tc) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + MW'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Resolves, in priority order, memory wait states, multi-cycle mul/div,
// taken branch/jump redirects and load-use hazards into hold/bubble
// controls for the F/D/E/M pipeline registers.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/flush
// cycle counters (perf_stall_cnt, perf_flush_cnt).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs1/id_rs2            : source indices of the D instruction
//   id_use_rs1/id_use_rs2    : D instruction actually reads that source
//   ex_rd, ex_is_load        : destination / load flag of the E instruction
//   ex_is_md                 : E instruction is mul/div
//   ex_jb                    : E resolved a taken branch/jump
//   imem_wait, dmem_wait     : fetch / data access not ready
//   stall_f/d/e/m            : hold PC / IF-ID / ID-EX / EX-MEM
//   flush_d/e/m              : load bubble into IF-ID / ID-EX / EX-MEM
//   md_done                  : mul/div result valid in E this cycle
//   perf_stall_cnt/flush_cnt : (PIPE_PERF_CNT_EN only) cycle counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_is_md,
    input  logic                 ex_jb,
    input  logic                 imem_wait,
    input  logic                 dmem_wait,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 stall_e,
    output logic                 flush_e,
    output logic                 stall_m,
    output logic                 flush_m,
    output logic                 md_done
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);

    logic memwait;
    logic md_stall;
    logic load_use;

    assign memwait  = imem_wait | dmem_wait;
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    pipe_md_timer #(
        .MD_LAT   (MD_LAT)
    ) u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (ex_is_md),
        .hold     (memwait),
        .md_stall (md_stall),
        .md_done  (md_done)
    );

    // Outputs are forced low while reset is asserted so an aborted mul/div
    // or a pending hazard cannot leak controls during reset.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        stall_m = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (memwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (md_stall) begin
            // E holds the mul/div op; M receives bubbles meanwhile.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (ex_jb) begin
            // Redirect squashes the D instruction, so any load-use is moot.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_f)
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (flush_d || flush_e)
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_is_md, ex_jb;
    logic       imem_wait, dmem_wait;
    logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, md_done;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_is_md   (ex_is_md),
        .ex_jb      (ex_jb),
        .imem_wait  (imem_wait),
        .dmem_wait  (dmem_wait),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .stall_e    (stall_e),
        .flush_e    (flush_e),
        .stall_m    (stall_m),
        .flush_m    (flush_m),
        .md_done    (md_done)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Packed view of all controls: {stall_f,stall_d,flush_d,stall_e,flush_e,stall_m,flush_m,md_done}
    function automatic logic [7:0] outs();
        return {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, md_done};
    endfunction

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_is_md = 1'b0; ex_jb = 1'b0;
        imem_wait = 1'b0; dmem_wait = 1'b0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ex_is_md = 1'b1;
        ex_jb = 1'b1;
        next_cycle(); #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs(), 8'b0);
        end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want %b", outs(), 8'b0);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b1100_1000) begin
            errors++;
            $display("FAIL load_use_rs1: got %b want %b", outs(), 8'b1100_1000);
        end
        // Bubble now in E: hazard disappears after exactly one cycle.
        next_cycle();
        ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL load_use_release: got %b want %b", outs(), 8'b0);
        end
        next_cycle();
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_use_rs2 = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b1100_1000) begin
            errors++;
            $display("FAIL load_use_rs2: got %b want %b", outs(), 8'b1100_1000);
        end
        next_cycle();
        id_use_rs2 = 1'b0;   // same index but not read -> no hazard
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL load_unused_src: got %b want %b", outs(), 8'b0);
        end
        next_cycle();
        idle_inputs();
        ex_is_load = 1'b0; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;   // ALU op, forwarded
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL non_load_dep: got %b want %b", outs(), 8'b0);
        end
        idle_inputs();
    endtask

    task automatic test_x0_load();
        next_cycle();
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL x0_load: got %b want %b", outs(), 8'b0);
        end
        idle_inputs();
    endtask

    task automatic test_jb_over_load_use();
        next_cycle();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; ex_jb = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b0010_1000) begin
            errors++;
            $display("FAIL jb_over_load_use: got %b want %b", outs(), 8'b0010_1000);
        end
        next_cycle();
        imem_wait = 1'b1;   // memory wait outranks redirect and hazard
        #1;
        checks++;
        if (outs() !== 8'b1101_0100) begin
            errors++;
            $display("FAIL memwait_priority: got %b want %b", outs(), 8'b1101_0100);
        end
        idle_inputs();
    endtask

    task automatic test_md();
        logic [7:0] exp;
        next_cycle();
        ex_is_md = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b1101_0010) begin
            errors++;
            $display("FAIL md_start: got %b want %b", outs(), 8'b1101_0010);
        end
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            ex_is_md = 1'b0;
            ex_jb = (i == 3);   // redirect during mul/div must be ignored
            #1;
            exp = (i < 7) ? 8'b1101_0010 : (i == 7) ? 8'b0000_0001 : 8'b0000_0000;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL md_cycle%0d: got %b want %b", i, outs(), exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_md_memwait();
        logic [7:0] exp;
        next_cycle();
        ex_is_md = 1'b1;
        #1;
        for (int i = 1; i <= 11; i++) begin
            next_cycle();
            ex_is_md = 1'b0;
            dmem_wait = (i >= 3 && i <= 5);
            #1;
            if (dmem_wait)       exp = 8'b1101_0100;
            else if (i < 10)     exp = 8'b1101_0010;
            else if (i == 10)    exp = 8'b0000_0001;
            else                 exp = 8'b0000_0000;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL md_wait_cycle%0d: got %b want %b", i, outs(), exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid_md();
        logic [7:0] exp;
        next_cycle();
        ex_is_md = 1'b1;
        #1;
        next_cycle(); ex_is_md = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL rst_mid_md: got %b want %b", outs(), 8'b0);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'b0000_0000) begin
            errors++;
            $display("FAIL run_after_rst: got %b want %b", outs(), 8'b0);
        end
        next_cycle();
        ex_is_md = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            ex_is_md = 1'b0;
            #1;
            exp = (i < 7) ? 8'b1101_0010 : (i == 7) ? 8'b0000_0001 : 8'b0000_0000;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL md_restart_cycle%0d: got %b want %b", i, outs(), exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_load();
        test_jb_over_load_use();
        test_md();
        test_md_memwait();
        test_rst_mid_md();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
